// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared widths, reset PC, state type and PC helper for the IF stage
//
// Purpose: bus widths for the IF->ID and EX->IF buses, default reset PC,
//          IF state enumeration and the sequential-PC helper.
// Ports:   none (package).
package if_stage_pkg;

  localparam int          IF_TO_ID_BUS_WIDTH = 64;
  localparam int          EX_TO_IF_BUS_WIDTH = 33;
  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;

  // STARTUP covers the single cycle after reset where no ROM read is in flight yet.
  typedef enum logic {
    ST_STARTUP = 1'b0,
    ST_RUN     = 1'b1
  } if_state_e;

  // Sequential PC, deliberately modulo 2^32 so 0xFFFF_FFFC wraps to 0.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// rtl/if_stage_pc_reg.sv - PC and held-PC registers with load enables
//
// Purpose: holds the fetch PC and the address of the instruction last
//          handed to ID, both async-reset to RESET_PC.
// Ports:   clk, rst        clock, async active-high reset
//          pc_we, pc_next  load enable / value for the fetch PC
//          held_we, held_next  load enable / value for held_pc
//          pc, held_pc     registered outputs
module pc_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_we,
  input  logic [31:0] pc_next,
  input  logic        held_we,
  input  logic [31:0] held_next,
  output logic [31:0] pc,
  output logic [31:0] held_pc
);

  logic [31:0] pc_d, pc_q;
  logic [31:0] held_pc_d, held_pc_q;

  always_comb begin
    pc_d      = pc_we   ? pc_next   : pc_q;
    held_pc_d = held_we ? held_next : held_pc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      held_pc_q <= RESET_PC;
    end else begin
      pc_q      <= pc_d;
      held_pc_q <= held_pc_d;
    end
  end

  assign pc      = pc_q;
  assign held_pc = held_pc_q;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - RV32I instruction-fetch stage, IF->ID valid/allow-in sender
//
// Purpose: owns the PC, drives the synchronous IROM address, applies EX
//          branch redirects and holds the ROM address while ID stalls.
// Ports:   clk, rst         clock, async active-high reset
//          ex_to_if_bus     {br_taken, br_target[31:0]} from EX
//          id_allow_in      ID can accept an instruction this cycle
//          irom_addr        byte address to the IROM (data next cycle)
//          if_to_id_bus     {pc4, pc} to ID
//          if_to_id_valid   bus carries a valid instruction
//          fetch_fault      sticky misaligned-branch-target flag
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [EX_TO_IF_BUS_WIDTH-1:0] ex_to_if_bus,
  input  logic                          id_allow_in,
  output logic [31:0]                   irom_addr,
  output logic [IF_TO_ID_BUS_WIDTH-1:0] if_to_id_bus,
  output logic                          if_to_id_valid,
  output logic                          fetch_fault
);

  logic        br_taken;
  logic [31:0] br_target;
  assign br_taken  = ex_to_if_bus[32];
  assign br_target = ex_to_if_bus[31:0];

  if_state_e   state_d, state_q;
  logic        fault_d, fault_q;
  logic        if_valid;
  logic        pc_we, held_we;
  logic [31:0] pc_next, held_next;
  logic [31:0] pc, held_pc, pc4;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .pc_we     (pc_we),
    .pc_next   (pc_next),
    .held_we   (held_we),
    .held_next (held_next),
    .pc        (pc),
    .held_pc   (held_pc)
  );

  assign if_valid = (state_q == ST_RUN);
  assign pc4      = pc_plus4(pc);

  always_comb begin
    state_d   = state_q;
    fault_d   = fault_q;
    pc_we     = 1'b0;
    pc_next   = pc;
    held_we   = 1'b0;
    held_next = pc;
    if (br_taken) begin
      // Redirect beats stall and startup; the low bits are dropped, not trapped.
      pc_we   = 1'b1;
      pc_next = {br_target[31:2], 2'b00};
      state_d = ST_RUN;
      if (br_target[1:0] != 2'b00) fault_d = 1'b1;
    end else if (!if_valid) begin
      state_d = ST_RUN;
    end else if (id_allow_in) begin
      pc_we   = 1'b1;
      pc_next = pc4;
      held_we = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_STARTUP;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  assign if_to_id_valid = if_valid && !br_taken;
  // Re-read the instruction ID holds unless this edge completes a handshake.
  assign irom_addr      = (if_valid && id_allow_in && !br_taken) ? pc : held_pc;
  assign if_to_id_bus   = {pc4, pc};
  assign fetch_fault    = fault_q;

endmodule
